// File: rtl/parallel_to_serial_rf.sv
// parallel_to_serial_rf: unloads a packed word of N_ELEMS elements onto a valid/ready
// serial port, successive elements at least II clocks apart. Define PTS_MSB_FIRST_EN for MSB-first order.
module parallel_to_serial_rf #(
  parameter int WIDTH   = 1,
  parameter int N_ELEMS = 2,
  parameter int II      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*N_ELEMS-1:0]   in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned IDX_W = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;

`ifdef PTS_MSB_FIRST_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(N_ELEMS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ELEMS - 1);
`endif

  if (WIDTH < 1 || N_ELEMS < 1 || II < 1) begin : g_param_check
    $fatal(1, "parallel_to_serial_rf: WIDTH, N_ELEMS and II must all be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [WIDTH*N_ELEMS-1:0] r_buf;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_idx_step;
  logic [31:0]              r_gap;
  logic                     w_xfer;
  logic                     w_load;
  logic                     w_gap_done;
  logic [WIDTH-1:0]         w_sel;

  assign w_xfer     = out_valid & out_ready;
  assign w_load     = in_valid & in_ready;
  assign w_gap_done = (r_gap == 32'(II - 2));

`ifdef PTS_MSB_FIRST_EN
  assign w_idx_step = r_idx - IDX_W'(1);
`else
  assign w_idx_step = r_idx + IDX_W'(1);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a load overlapping the last transfer still honours the II spacing
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_load) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (w_xfer) begin
          if (out_last && !w_load) w_state_nxt = S_IDLE;
          else                     w_state_nxt = (II == 1) ? S_EMIT : S_GAP;
        end
      end
      S_GAP: begin
        if (w_gap_done) w_state_nxt = S_EMIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registers only; in_ready also looks at out_ready
  always_comb begin
    out_valid = (r_state == S_EMIT);
    out_last  = out_valid && (r_idx == LAST_IDX);
    out       = out_valid ? w_sel : '0;
    busy      = (r_state != S_IDLE);
    in_ready  = (r_state == S_IDLE) | (out_valid & out_ready & out_last);
  end

  // Element select on the held buffer
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_ELEMS; k++) begin
      if (r_idx == IDX_W'(k)) w_sel = r_buf[k*WIDTH +: WIDTH];
    end
  end

  // Word buffer, element index and inter-element gap counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf <= '0;
      r_idx <= '0;
      r_gap <= '0;
    end else begin
      if (w_load) begin
        r_buf <= in;
        r_idx <= FIRST_IDX;
      end else if (w_xfer && !out_last) begin
        r_idx <= w_idx_step;
      end
      if (r_state == S_GAP) begin
        r_gap <= w_gap_done ? '0 : r_gap + 32'd1;
      end
    end
  end

  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (!rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(out_last)));

  a_out_zero_when_invalid : assert property (
    @(posedge clk) disable iff (!rst)
    !out_valid |-> (out == '0 && !out_last));

  a_idle_accepts : assert property (
    @(posedge clk) disable iff (!rst)
    !busy |-> in_ready);

endmodule

// File: tb/tb_parallel_to_serial_rf.sv
// Bench for parallel_to_serial_rf: two instances (II=1 and II=3) checked every cycle
// against an element-queue model, plus literal sequences for the documented scenarios.
module tb_parallel_to_serial_rf;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int NL    = 2;
  localparam int WW    = WIDTH * N;
  localparam int II_L0 = 1;
  localparam int II_L1 = 3;

  localparam logic [WW-1:0] WORD_A = 32'h44332211;
  localparam logic [WW-1:0] WORD_B = 32'h88776655;
  localparam logic [WW-1:0] WORD_C = 32'hDDCCBBAA;
`ifdef PTS_MSB_FIRST_EN
  localparam logic [63:0]   LIT_SEQ   = 64'h5566778811223344;
  localparam logic [7:0]    LIT_FIRST = 8'hDD;
`else
  localparam logic [63:0]   LIT_SEQ   = 64'h8877665544332211;
  localparam logic [7:0]    LIT_FIRST = 8'hAA;
`endif

  logic                         clk;
  logic                         rst;
  logic [NL-1:0]                in_valid;
  logic [NL-1:0]                in_ready;
  logic [NL-1:0][WW-1:0]        in_word;
  logic [NL-1:0]                out_valid;
  logic [NL-1:0]                out_ready;
  logic [NL-1:0][WIDTH-1:0]     out_d;
  logic [NL-1:0]                out_last;
  logic [NL-1:0]                busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: word being sent, elements already sent, idle cycles still owed before the next one
  logic [WW-1:0] m_word    [NL];
  int            m_pos     [NL];
  int            m_wait    [NL];
  bit            m_busy    [NL];
  bit            m_loaded  [NL];
  bit            p_pending [NL];
  logic [WW-1:0] p_word    [NL];

  parallel_to_serial_rf #(.WIDTH(WIDTH), .N_ELEMS(N), .II(II_L0)) u_dut_ii1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in(in_word[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out_d[0]),
    .out_last(out_last[0]), .busy(busy[0])
  );

  parallel_to_serial_rf #(.WIDTH(WIDTH), .N_ELEMS(N), .II(II_L1)) u_dut_ii3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in(in_word[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out_d[1]),
    .out_last(out_last[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int ii_of(input logic li);
    return li ? II_L1 : II_L0;
  endfunction

  function automatic logic e_valid(input logic li);
    return m_busy[li] && (m_wait[li] == 0);
  endfunction

  function automatic logic e_last(input logic li);
    return e_valid(li) && (m_pos[li] == N - 1);
  endfunction

  function automatic logic [WIDTH-1:0] e_out(input logic li);
    int k;
    if (!e_valid(li)) return '0;
`ifdef PTS_MSB_FIRST_EN
    k = N - 1 - m_pos[li];
`else
    k = m_pos[li];
`endif
    return WIDTH'(m_word[li] >> (k * WIDTH));
  endfunction

  function automatic logic e_in_ready(input logic li);
    return !m_busy[li] || (e_last(li) && out_ready[li]);
  endfunction

  function automatic logic [7:0] lit_of(input int k);
    return 8'(LIT_SEQ >> (8 * k));
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_word[1'(l)]    = '0;
      m_pos[1'(l)]     = 0;
      m_wait[1'(l)]    = 0;
      m_busy[1'(l)]    = 1'b0;
      m_loaded[1'(l)]  = 1'b0;
      p_pending[1'(l)] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge using the inputs currently driven
  task automatic model_step(input logic li);
    logic xfer, last, load, was_busy, wait_set;
    xfer     = e_valid(li) && out_ready[li];
    last     = e_last(li);
    load     = in_valid[li] && e_in_ready(li);
    was_busy = m_busy[li];
    wait_set = 1'b0;
    if (xfer) begin
      if (last) begin
        m_busy[li] = 1'b0;
      end else begin
        m_pos[li]++;
        m_wait[li] = ii_of(li) - 1;
        wait_set   = 1'b1;
      end
    end
    if (load) begin
      m_word[li] = in_word[li];
      m_pos[li]  = 0;
      m_busy[li] = 1'b1;
      m_wait[li] = was_busy ? ii_of(li) - 1 : 0;
      wait_set   = 1'b1;
    end
    if (!wait_set && m_wait[li] > 0) m_wait[li]--;
    m_loaded[li] = load;
  endtask

  task automatic compare_lane(input logic li);
    check($sformatf("out_valid L%0d", li), 32'(out_valid[li]), 32'(e_valid(li)));
    check($sformatf("out L%0d", li),       32'(out_d[li]),     32'(e_out(li)));
    check($sformatf("out_last L%0d", li),  32'(out_last[li]),  32'(e_last(li)));
    check($sformatf("busy L%0d", li),      32'(busy[li]),      32'(m_busy[li]));
    check($sformatf("in_ready L%0d", li),  32'(in_ready[li]),  32'(e_in_ready(li)));
  endtask

  // Called at a falling edge: drive, compare, step the model, move to the next falling edge
  task automatic run_cycle();
    for (int l = 0; l < NL; l++) begin
      in_valid[1'(l)] = p_pending[1'(l)];
      in_word[1'(l)]  = p_word[1'(l)];
    end
    #1;
    for (int l = 0; l < NL; l++) compare_lane(1'(l));
    for (int l = 0; l < NL; l++) begin
      model_step(1'(l));
      if (m_loaded[1'(l)]) p_pending[1'(l)] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic lit_lane(input string tag, input logic li, input logic v,
                          input logic [7:0] d, input logic last);
    check($sformatf("%s.valid L%0d", tag, li), 32'(out_valid[li]), 32'(v));
    check($sformatf("%s.out L%0d", tag, li),   32'(out_d[li]),     32'(v ? d : 8'h00));
    check($sformatf("%s.last L%0d", tag, li),  32'(out_last[li]),  32'(last));
  endtask

  task automatic load_both(input logic [WW-1:0] w);
    for (int l = 0; l < NL; l++) begin
      p_pending[1'(l)] = 1'b1;
      p_word[1'(l)]    = w;
    end
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    out_ready = '1;
    while ((m_busy[0] || m_busy[1] || p_pending[0] || p_pending[1]) && guard < 200) begin
      run_cycle();
      guard++;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; released on a falling edge
  task automatic async_reset_pulse();
    #2;
    rst = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("arst.out_valid L%0d", l), 32'(out_valid[1'(l)]), 32'd0);
      check($sformatf("arst.out L%0d", l),       32'(out_d[1'(l)]),     32'd0);
      check($sformatf("arst.busy L%0d", l),      32'(busy[1'(l)]),      32'd0);
      check($sformatf("arst.in_ready L%0d", l),  32'(in_ready[1'(l)]),  32'd1);
    end
    model_reset();
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = '0;
    in_word   = '0;
    out_ready = '1;
    for (int l = 0; l < NL; l++) p_word[1'(l)] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      lit_lane("reset", 1'(l), 1'b0, 8'h00, 1'b0);
      check($sformatf("reset.busy L%0d", l),     32'(busy[1'(l)]),     32'd0);
      check($sformatf("reset.in_ready L%0d", l), 32'(in_ready[1'(l)]), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);

    // Single word: lane 0 back-to-back elements, lane 1 on cycles 1,4,7,10
    load_both(WORD_A);
    run_cycle();
    for (int c = 1; c <= 11; c++) begin
      lit_lane("basic", 1'b0, c <= 4, lit_of(c - 1), c == 4);
      check($sformatf("basic.in_ready c%0d", c), 32'(in_ready[0]), 32'(c >= 4));
      lit_lane("ii3", 1'b1, (c <= 10) && ((c - 1) % 3 == 0), lit_of((c - 1) / 3), c == 10);
      run_cycle();
    end
    drain();

    // Backpressure on cycles 2-4 while the second element is presented
    load_both(WORD_A);
    run_cycle();
    for (int c = 1; c <= 8; c++) begin
      out_ready = (c >= 2 && c <= 4) ? 2'b00 : 2'b11;
      lit_lane("bp", 1'b0, c <= 7,
               lit_of(c == 1 ? 0 : (c <= 5 ? 1 : c - 4)), c == 7);
      run_cycle();
    end
    drain();

    // Back-to-back words with the producer holding in_valid
    load_both(WORD_A);
    run_cycle();
    load_both(WORD_B);
    for (int c = 1; c <= 23; c++) begin
      lit_lane("b2b", 1'b0, c <= 8, lit_of(c - 1), c == 4 || c == 8);
      check($sformatf("b2b.in_ready c%0d", c), 32'(in_ready[0]), 32'(c == 4 || c >= 8));
      lit_lane("b2b_ii3", 1'b1, (c <= 22) && ((c - 1) % 3 == 0), lit_of((c - 1) / 3),
               c == 10 || c == 22);
      run_cycle();
    end
    drain();

    // Reset while the second element is presented; next word restarts at element 0
    load_both(WORD_A);
    run_cycle();
    run_cycle();
    lit_lane("pre_rst", 1'b0, 1'b1, lit_of(1), 1'b0);
    async_reset_pulse();
    load_both(WORD_C);
    run_cycle();
    lit_lane("post_rst", 1'b0, 1'b1, LIT_FIRST, 1'b0);
    lit_lane("post_rst", 1'b1, 1'b1, LIT_FIRST, 1'b0);
    drain();

    // Random traffic and backpressure, with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      for (int l = 0; l < NL; l++) begin
        if (!p_pending[1'(l)] && $urandom_range(0, 3) != 0) begin
          p_pending[1'(l)] = 1'b1;
          p_word[1'(l)]    = WW'($urandom);
        end
        out_ready[1'(l)] = ($urandom_range(0, 9) < 7);
      end
      if ($urandom_range(0, 799) == 0) async_reset_pulse();
      else                             run_cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
